// File: rtl/scan_config_loader.sv
// Configuration scan-chain loader: serializes host words onto scan_in with scan_en,
// and packs the bits leaving the chain into readback words.
module scan_config_loader #(
  parameter int CHAIN_LEN  = 12,
  parameter int WORD_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [WORD_WIDTH-1:0] i_cfg_data,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  output logic                  o_scan_in,
  output logic                  o_scan_en,
  input  logic                  i_scan_out,
  output logic [WORD_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int RW = $clog2(CHAIN_LEN + 1);
  localparam int CW = $clog2(WORD_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [RW-1:0]         r_rem;
  logic [CW-1:0]         r_nbits, r_left, r_k;
  logic [WORD_WIDTH-1:0] r_sreg, r_col, r_rd_data;
  logic                  r_rd_valid;

  logic                  w_xfer, w_word_end, w_chain_end;
  logic [CW-1:0]         w_nbits, w_k_inc;
  logic [WORD_WIDTH-1:0] w_col_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_xfer      = 1'b0;
    w_word_end  = 1'b0;
    w_chain_end = 1'b0;
    w_nbits     = (32'(r_rem) < WORD_WIDTH) ? CW'(r_rem) : CW'(WORD_WIDTH);
    w_k_inc     = r_k + CW'(1);
    w_col_nxt   = r_col | (WORD_WIDTH'(i_scan_out) << r_k);
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (i_cfg_valid) begin
          w_xfer      = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_left == '0) begin
          w_word_end  = 1'b1;
          w_chain_end = (r_rem == RW'(r_nbits));
          w_state_nxt = w_chain_end ? S_DONE : S_LOAD;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // scan_en and scan_in come straight from registers: SHIFT state and sreg LSB.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem      <= '0;
      r_nbits    <= '0;
      r_left     <= '0;
      r_k        <= '0;
      r_sreg     <= '0;
      r_col      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (r_state == S_IDLE && i_start) r_rem <= RW'(CHAIN_LEN);
      if (w_xfer) begin
        r_sreg  <= i_cfg_data;
        r_nbits <= w_nbits;
        r_left  <= w_nbits - CW'(1);
      end
      if (r_state == S_SHIFT) begin
        if (w_word_end) begin
          r_sreg <= '0;
          r_rem  <= r_rem - RW'(r_nbits);
        end else begin
          r_sreg <= r_sreg >> 1;
          r_left <= r_left - CW'(1);
        end
        // The bit at the far end leaves the chain on this edge.
        if (w_k_inc == CW'(WORD_WIDTH) || w_chain_end) begin
          r_rd_data  <= w_col_nxt;
          r_rd_valid <= 1'b1;
          r_col      <= '0;
          r_k        <= '0;
        end else begin
          r_col <= w_col_nxt;
          r_k   <= w_k_inc;
        end
      end
    end
  end

  assign o_cfg_ready = (r_state == S_LOAD);
  assign o_scan_en   = (r_state == S_SHIFT);
  assign o_scan_in   = (r_state == S_SHIFT) & r_sreg[0];
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;
endmodule

// File: tb/tb_scan_config_loader.sv
// Directed bench for scan_config_loader: 12-bit chain with 8-bit words, plus an 8/8 instance.
module tb_scan_config_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, cfg_valid, cfg_ready, scan_in, scan_en, scan_out, rd_valid, busy, done;
  logic [7:0] cfg_data, rd_data;
  logic       start2, cfg_valid2, cfg_ready2, scan_in2, scan_en2, scan_out2, rd_valid2, busy2, done2;
  logic [7:0] cfg_data2, rd_data2;

  scan_config_loader #(.CHAIN_LEN(12), .WORD_WIDTH(8)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_cfg_data(cfg_data), .i_cfg_valid(cfg_valid),
    .o_cfg_ready(cfg_ready), .o_scan_in(scan_in), .o_scan_en(scan_en), .i_scan_out(scan_out),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_busy(busy), .o_done(done));

  scan_config_loader #(.CHAIN_LEN(8), .WORD_WIDTH(8)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_cfg_data(cfg_data2), .i_cfg_valid(cfg_valid2),
    .o_cfg_ready(cfg_ready2), .o_scan_in(scan_in2), .o_scan_en(scan_en2), .i_scan_out(scan_out2),
    .o_rd_data(rd_data2), .o_rd_valid(rd_valid2), .o_busy(busy2), .o_done(done2));

  // Chain models: scan_in enters at the top bit, bit 0 is the far end feeding scan_out.
  logic        pre_en;
  logic [11:0] pre_val, chain;
  logic [7:0]  pre_val2, chain2;
  always @(posedge clk) begin
    if (pre_en) begin
      chain  <= pre_val;
      chain2 <= pre_val2;
    end else begin
      if (scan_en)  chain  <= {scan_in, chain[11:1]};
      if (scan_en2) chain2 <= {scan_in2, chain2[7:1]};
    end
  end
  assign scan_out  = chain[0];
  assign scan_out2 = chain2[0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        clr, prev_en;
  int          en_cnt, done_cnt, rd_cnt, nruns, both, en2_cnt, rd2_cnt, done2_cnt, last_en2, done2_cyc;
  int          runs[4];
  logic [15:0] sin_vec;
  logic [7:0]  rd_log[8];
  logic [7:0]  rd2_last;
  always @(negedge clk) begin
    if (clr) begin
      en_cnt = 0; done_cnt = 0; rd_cnt = 0; nruns = 0; both = 0; prev_en = 0; sin_vec = '0;
      en2_cnt = 0; rd2_cnt = 0; done2_cnt = 0; last_en2 = 0; done2_cyc = 0; rd2_last = '0;
      for (int i = 0; i < 4; i++) runs[i] = 0;
    end else begin
      if (scan_en) begin
        if (!prev_en && nruns < 4) nruns++;
        if (nruns > 0) runs[nruns-1]++;
        if (en_cnt < 16) sin_vec[en_cnt] = scan_in;
        en_cnt++;
      end
      prev_en = scan_en;
      if (rd_valid) begin
        if (rd_cnt < 8) rd_log[rd_cnt] = rd_data;
        rd_cnt++;
      end
      if (done) done_cnt++;
      if (done && rd_valid) both++;
      if (scan_en2) begin en2_cnt++; last_en2 = cyc; end
      if (rd_valid2) begin rd2_cnt++; rd2_last = rd_data2; end
      if (done2) begin done2_cnt++; done2_cyc = cyc; end
    end
  end

  int n_tests = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    clr = 1'b1; @(negedge clk); #1; clr = 1'b0;
  endtask

  task automatic preload(input logic [11:0] v, input logic [7:0] v2);
    pre_val = v; pre_val2 = v2; pre_en = 1'b1; tick(); pre_en = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cfg_ready && n < 100) begin tick(); n++; end
    if (n >= 100) check("ready_timeout", {31'd0, cfg_ready}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    check("idle", {31'd0, busy}, 32'd0);
    tick(); tick();
  endtask

  task automatic do_load(input logic [7:0] w0, input logic [7:0] w1, input int stall, input bit mid_start);
    logic [7:0]  w[2];
    logic [11:0] cb;
    w[0] = w0; w[1] = w1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_ready();
      if (i == 0 && stall > 0) begin
        cb = chain;
        for (int s = 0; s < stall; s++) begin
          check("stall_ready", {31'd0, cfg_ready}, 32'd1);
          check("stall_scan_en", {31'd0, scan_en}, 32'd0);
          tick();
        end
        check("stall_chain", {20'd0, chain}, {20'd0, cb});
      end
      cfg_data = w[i]; cfg_valid = 1'b1; tick(); cfg_valid = 1'b0; cfg_data = '0;
      if (i == 0 && mid_start) begin
        tick(); tick(); start = 1'b1; tick(); start = 1'b0;
      end
    end
    wait_idle();
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 0; cfg_valid = 0; cfg_data = '0; start2 = 0; cfg_valid2 = 0; cfg_data2 = '0;
    pre_en = 0; pre_val = '0; pre_val2 = '0; clr = 1'b1;
    tick(); tick();
    check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    check("rst_scan_en", {31'd0, scan_en}, 32'd0);
    check("rst_scan_in", {31'd0, scan_in}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rd", {23'd0, rd_valid, rd_data}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic load into an all-ones chain.
    preload(12'hFFF, 8'h5A);
    clear_mon();
    do_load(8'hA5, 8'h0C, 0, 0);
    check("t1_runs", nruns, 2);
    check("t1_run0", runs[0], 8);
    check("t1_run1", runs[1], 4);
    check("t1_scan_in", {20'd0, sin_vec[11:0]}, 32'hCA5);
    check("t1_chain", {20'd0, chain}, 32'hCA5);
    check("t1_rd_cnt", rd_cnt, 2);
    check("t1_rd0", {24'd0, rd_log[0]}, 32'hFF);
    check("t1_rd1", {24'd0, rd_log[1]}, 32'h0F);
    check("t1_done", done_cnt, 1);
    check("t1_done_with_rd", both, 1);

    // Readback of the previous configuration.
    clear_mon();
    do_load(8'h3C, 8'h77, 0, 0);
    check("t2_rd0", {24'd0, rd_log[0]}, 32'hA5);
    check("t2_rd1", {24'd0, rd_log[1]}, 32'h0C);
    check("t2_chain", {20'd0, chain}, 32'h73C);

    // Host stalls in LOAD.
    clear_mon();
    do_load(8'h12, 8'h34, 5, 0);
    check("t3_en_cnt", en_cnt, 12);
    check("t3_rd0", {24'd0, rd_log[0]}, 32'h3C);
    check("t3_rd1", {24'd0, rd_log[1]}, 32'h07);
    check("t3_chain", {20'd0, chain}, 32'h412);
    check("t3_done", done_cnt, 1);

    // start pulsed during SHIFT is ignored.
    clear_mon();
    do_load(8'h5A, 8'hF0, 0, 1);
    check("t4_en_cnt", en_cnt, 12);
    check("t4_done", done_cnt, 1);
    check("t4_rd0", {24'd0, rd_log[0]}, 32'h12);
    check("t4_rd1", {24'd0, rd_log[1]}, 32'h04);
    check("t4_chain", {20'd0, chain}, 32'h05A);
    tick(); tick();
    check("t4_idle_after", {30'd0, busy, scan_en}, 32'd0);

    // Reset on the third shift cycle.
    clear_mon();
    start = 1'b1; tick(); start = 1'b0;
    wait_ready();
    cfg_data = 8'hA5; cfg_valid = 1'b1; tick(); cfg_valid = 1'b0; cfg_data = '0;
    tick(); tick();
    check("t5_shifting", {31'd0, scan_en}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_scan_en", {31'd0, scan_en}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("t5_no_done", done_cnt, 0);
    check("t5_no_rd", rd_cnt, 0);
    clear_mon();
    do_load(8'hA5, 8'h0C, 0, 0);
    check("t5_reload_en", en_cnt, 12);
    check("t5_reload_chain", {20'd0, chain}, 32'hCA5);
    check("t5_reload_rd", rd_cnt, 2);
    check("t5_reload_done", done_cnt, 1);

    // Single full word on the 8/8 instance.
    preload(chain, 8'h5A);
    clear_mon();
    start2 = 1'b1; tick(); start2 = 1'b0;
    n = 0;
    while (!cfg_ready2 && n < 100) begin tick(); n++; end
    check("t6_ready", {31'd0, cfg_ready2}, 32'd1);
    cfg_data2 = 8'h3C; cfg_valid2 = 1'b1; tick(); cfg_valid2 = 1'b0; cfg_data2 = '0;
    n = 0;
    while (busy2 && n < 100) begin tick(); n++; end
    check("t6_idle", {31'd0, busy2}, 32'd0);
    tick(); tick();
    check("t6_en_cnt", en2_cnt, 8);
    check("t6_rd_cnt", rd2_cnt, 1);
    check("t6_rd_data", {24'd0, rd2_last}, 32'h5A);
    check("t6_done_cnt", done2_cnt, 1);
    check("t6_done_timing", done2_cyc, last_en2 + 1);
    check("t6_chain", {24'd0, chain2}, 32'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/scan_config_loader.md
Name: scan_config_loader

Overview:
- Drives the configuration scan chain that runs through the CLB, BLE LUT SRAM and connection-box shift registers.
- Accepts bitstream words over a valid/ready handshake, serializes them onto scan_in, and asserts scan_en for exactly CHAIN_LEN shift cycles per load.
- Captures the bits emerging from the chain's scan_out and returns them as readback words, so the host can verify the previous configuration.

Parameters:
CHAIN_LEN, 12, total scan-chain length in bits; must be >= 1.
WORD_WIDTH, 8, bitstream and readback word width; must be >= 1.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin a load; honoured only in IDLE.
cfg_data  input  WORD_WIDTH  bitstream word; bit 0 is shifted first.
cfg_valid  input  1  cfg_data is valid.
cfg_ready  output  1  loader accepts a word this cycle.
scan_in  output  1  serial data into the chain (registered).
scan_en  output  1  chain shift enable (registered).
scan_out  input  1  serial data leaving the far end of the chain.
rd_data  output  WORD_WIDTH  readback word, packed LSB-first.
rd_valid  output  1  one-cycle pulse; rd_data is valid. No backpressure.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse after the last bit has been shifted.

Behaviour:
- Reset: state=IDLE. cfg_ready, scan_in, scan_en, rd_valid, busy and done are all 0. rd_data is 0. All counters are 0. Reset mid-load aborts immediately: scan_en is 0 on the next cycle, and no done or rd_valid pulse is produced.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start=1 -> LOAD; remaining bit count is set to CHAIN_LEN.
  - start in any other state is ignored.
- LOAD:
  - cfg_ready=1 and scan_en=0.
  - A transfer occurs when cfg_valid & cfg_ready. The word is latched into the shift register, and nbits = min(WORD_WIDTH, remaining) -> SHIFT.
  - With cfg_valid=0 the block stays in LOAD. The chain holds its contents.
- SHIFT:
  - cfg_ready=0.
  - Each cycle: scan_en=1, and scan_in = the current bit, taken from the LSB first. The shift register then moves right by one.
  - Exactly nbits cycles are spent here. A transfer in cycle N gives scan_en high in cycles N+1 .. N+nbits.
  - On the final bit, remaining is decremented by nbits. If remaining becomes 0 -> DONE, otherwise -> LOAD.
  - There is at least one cycle with scan_en=0 between words. The chain tolerates gaps.
- DONE: done=1 for one cycle, scan_en=0 -> IDLE. busy falls in the same cycle as the return to IDLE.
- Last word: only the low (CHAIN_LEN mod WORD_WIDTH) bits are shifted when the remainder is nonzero. The upper bits of that word are ignored.
- Readback:
  - At every rising edge where scan_en=1, scan_out is sampled, since it is the bit leaving the chain at that edge. The sample is packed into a collector at index k, which counts 0 up to WORD_WIDTH-1.
  - When k reaches WORD_WIDTH, or on the final chain bit, rd_data is updated with the collected word and rd_valid pulses on the next cycle.
  - Unfilled upper bits of a partial word are 0. The collector is cleared after each word.
- Bit order: the first bit shifted in ends up at the far end of the chain. The first bit read back is the former far-end bit.
- Counter widths: $clog2(CHAIN_LEN+1) for remaining, and $clog2(WORD_WIDTH+1) for nbits and k.
- Simultaneous events:
  - cfg_valid asserted in SHIFT is not accepted; cfg_ready=0 there.
  - start together with rst: rst wins.
  - The rd_valid for the final word and done are produced in the same cycle.

Test Plan:
- Defaults, reset, then start. Send cfg_data=8'hA5 then 8'h0C, with the chain model preloaded to 12'hFFF.
  - Required: scan_en is high for 8 cycles then 4 cycles.
  - Required: scan_in sequence is 1,0,1,0,0,1,0,1, then 0,0,1,1.
  - Required: chain ends holding 12'hCA5, with its first bit at the far end.
  - Required: rd_data is 8'hFF then 8'h0F, and done pulses once.
- Readback of the previous load: start again with any two words.
  - Required: rd_data is 8'hA5 then 8'h0C.
- Stalled host: hold cfg_valid=0 for 5 cycles in LOAD.
  - Required: cfg_ready stays 1 and scan_en stays 0 throughout.
  - Required: the chain contents are unchanged and the load completes normally afterwards.
- Start ignored while busy: pulse start during SHIFT.
  - Required: no effect; there are exactly 12 scan_en cycles in total and one done pulse.
- Reset mid-load: assert rst at the 3rd shift cycle.
  - Required: the next cycle has scan_en=0, busy=0 and cfg_ready=0.
  - Required: no done and no rd_valid; a following full load succeeds.
- CHAIN_LEN=8, WORD_WIDTH=8 with one word 8'h3C.
  - Required: 8 shift cycles, one rd_valid, and done one cycle after the last shift.
